// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage pipelined floating-point normaliser.
// Stage 1 captures the operand and counts leading zeros of hidden+fraction.
// Stage 2 selects carry / zero / underflow / left-shift handling, detects
// exponent overflow, and holds the result in the output register.
// Both stages use a valid/ready stream handshake, so backpressure stalls the
// pipe without losing or duplicating beats.

module fp_norm_pipe #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W+1:0] mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MANT_W-1:0] mant_out,
  output logic              zero_out,
  output logic              ovf_out,
  output logic              unf_out
);

  // Leading-zero count covers 0..MANT_W+1, so it needs enough bits for MANT_W+1.
  localparam int LZ_W = $clog2(MANT_W + 2);
  // Width of the exponent arithmetic; one spare bit so +1 can never wrap.
  localparam int XW   = EXP_W + 1;
  // Threshold at which an incremented exponent becomes infinity.
  localparam logic [XW-1:0] EXP_INF = {1'b0, {EXP_W{1'b1}}};

  // Count leading zeros of the hidden+fraction field (MSB first).
  function automatic logic [LZ_W-1:0] count_lz(input logic [MANT_W:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = {LZ_W{1'b0}};
    found = 1'b0;
    for (int i = MANT_W; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + LZ_W'(1);
      end
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid_r;
  logic out_valid_r;
  logic s2_adv_s;
  logic s1_adv_s;
  logic accept_s;

  // The output register can take new data when empty or being drained this
  // cycle; stage 1 can move when empty or when stage 2 is moving.
  assign s2_adv_s = !out_valid_r || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;
  assign accept_s = in_valid && s1_adv_s;

  // ---------------------------------------------------------------------
  // Stage 1: operand capture and leading-zero count
  // ---------------------------------------------------------------------
  logic              s1_sign_r;
  logic [EXP_W-1:0]  s1_exp_r;
  logic [MANT_W+1:0] s1_mant_r;
  logic [LZ_W-1:0]   s1_lzc_r;
  logic [LZ_W-1:0]   lzc_s;

  assign lzc_s = count_lz(mant_in[MANT_W:0]);

  // Stage 1 register: advances whenever stage 1 can move; data only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_exp_r   <= {EXP_W{1'b0}};
      s1_mant_r  <= {(MANT_W+2){1'b0}};
      s1_lzc_r   <= {LZ_W{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_sign_r <= sign_in;
        s1_exp_r  <= exp_in;
        s1_mant_r <= mant_in;
        s1_lzc_r  <= lzc_s;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: normalisation decision
  // ---------------------------------------------------------------------
  logic              carry_s;
  logic              mant_nz_s;
  logic [XW-1:0]     exp_ext_s;
  logic [XW-1:0]     lzc_ext_s;
  logic [XW-1:0]     exp_inc_s;
  logic [EXP_W-1:0]  exp_dec_s;
  logic [MANT_W-1:0] shifted_s;

  logic [EXP_W-1:0]  nxt_exp_s;
  logic [MANT_W-1:0] nxt_mant_s;
  logic              nxt_zero_s;
  logic              nxt_ovf_s;
  logic              nxt_unf_s;

  assign carry_s   = s1_mant_r[MANT_W+1];
  assign mant_nz_s = |s1_mant_r[MANT_W:0];
  assign exp_ext_s = {1'b0, s1_exp_r};
  assign lzc_ext_s = XW'(s1_lzc_r);
  assign exp_inc_s = exp_ext_s + XW'(1);
  // Only used when exp > lzc, so the subtraction cannot go negative.
  assign exp_dec_s = s1_exp_r - EXP_W'(s1_lzc_r);
  assign shifted_s = MANT_W'(s1_mant_r[MANT_W:0] << s1_lzc_r);

  // Priority: carry (with overflow check), exact zero, underflow flush, shift.
  always_comb begin
    nxt_exp_s  = {EXP_W{1'b0}};
    nxt_mant_s = {MANT_W{1'b0}};
    nxt_zero_s = 1'b0;
    nxt_ovf_s  = 1'b0;
    nxt_unf_s  = 1'b0;
    if (carry_s) begin
      if (exp_inc_s >= EXP_INF) begin
        nxt_exp_s = {EXP_W{1'b1}};
        nxt_ovf_s = 1'b1;
      end else begin
        nxt_exp_s  = exp_inc_s[EXP_W-1:0];
        nxt_mant_s = s1_mant_r[MANT_W:1];
      end
    end else if (!mant_nz_s) begin
      nxt_zero_s = 1'b1;
    end else if (exp_ext_s <= lzc_ext_s) begin
      // No denormal output: anything that would land at or below zero flushes.
      nxt_zero_s = 1'b1;
      nxt_unf_s  = 1'b1;
    end else begin
      nxt_exp_s  = exp_dec_s;
      nxt_mant_s = shifted_s;
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic              sign_r;
  logic [EXP_W-1:0]  exp_r;
  logic [MANT_W-1:0] mant_r;
  logic              zero_r;
  logic              ovf_r;
  logic              unf_r;

  // Output stage: loads a new result when it may advance, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sign_r      <= 1'b0;
      exp_r       <= {EXP_W{1'b0}};
      mant_r      <= {MANT_W{1'b0}};
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sign_r <= s1_sign_r;
        exp_r  <= nxt_exp_s;
        mant_r <= nxt_mant_s;
        zero_r <= nxt_zero_s;
        ovf_r  <= nxt_ovf_s;
        unf_r  <= nxt_unf_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign sign_out  = sign_r;
  assign exp_out   = exp_r;
  assign mant_out  = mant_r;
  assign zero_out  = zero_r;
  assign ovf_out   = ovf_r;
  assign unf_out   = unf_r;

endmodule

// File: tb/tb_fp_norm_pipe.sv
// Self-checking bench for fp_norm_pipe: directed vectors with latency checks,
// backpressure, random valid/ready traffic against a reference model kept in
// a scoreboard queue, and asynchronous reset in mid-stream.

module tb_fp_norm_pipe;

  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam int RW     = 1 + EXP_W + MANT_W + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              sign_in = 1'b0;
  logic [EXP_W-1:0]  exp_in = '0;
  logic [MANT_W+1:0] mant_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic              zero_out;
  logic              ovf_out;
  logic              unf_out;

  int checks = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  logic          acc = 1'b0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_res = '0;

  always #5 clk = ~clk;

  fp_norm_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out),
    .zero_out(zero_out), .ovf_out(ovf_out), .unf_out(unf_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [RW-1:0] pk(input logic s, input logic [EXP_W-1:0] e,
                                       input logic [MANT_W-1:0] m, input logic z,
                                       input logic o, input logic u);
    return {s, e, m, z, o, u};
  endfunction

  function automatic logic [RW-1:0] cur_out();
    return {sign_out, exp_out, mant_out, zero_out, ovf_out, unf_out};
  endfunction

  // Reference: normalise by shifting until the hidden bit is set.
  function automatic logic [RW-1:0] model(input logic s, input logic [EXP_W-1:0] e,
                                          input logic [MANT_W+1:0] m);
    logic [MANT_W:0]   mm;
    logic [EXP_W-1:0]  eo;
    logic [MANT_W-1:0] mo;
    logic z, o, u;
    int lz;
    eo = '0; mo = '0; z = 1'b0; o = 1'b0; u = 1'b0; lz = 0;
    if (m[MANT_W+1]) begin
      if (int'(e) + 1 >= (1 << EXP_W) - 1) begin
        eo = '1; o = 1'b1;
      end else begin
        eo = EXP_W'(int'(e) + 1); mo = m[MANT_W:1];
      end
    end else if (m[MANT_W:0] == '0) begin
      z = 1'b1;
    end else begin
      mm = m[MANT_W:0];
      while (!mm[MANT_W]) begin
        mm = mm << 1;
        lz++;
      end
      if (int'(e) <= lz) begin
        z = 1'b1; u = 1'b1;
      end else begin
        eo = EXP_W'(int'(e) - lz); mo = mm[MANT_W-1:0];
      end
    end
    return {s, eo, mo, z, o, u};
  endfunction

  // One cycle: drive at negedge, evaluate handshakes that fire on the next posedge.
  task automatic step(input logic v, input logic s, input logic [EXP_W-1:0] e,
                      input logic [MANT_W+1:0] m, input logic r);
    @(negedge clk);
    in_valid = v; sign_in = s; exp_in = e; mant_in = m; out_ready = r;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(cur_out()), 64'(prev_res));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else chk("result", 64'(cur_out()), 64'(exp_q.pop_front()));
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(s, e, m));
    prev_stall = out_valid && !out_ready;
    prev_res = cur_out();
  endtask

  // Single beat with exact 2-cycle latency and spec-given expected value.
  task automatic directed(input string tag, input logic s, input logic [EXP_W-1:0] e,
                          input logic [MANT_W+1:0] m, input logic [RW-1:0] want);
    step(1'b1, s, e, m, 1'b1);
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk({tag, "_val"}, 64'(cur_out()), 64'(want));
  endtask

  function automatic logic [MANT_W+1:0] rand_mant();
    int md;
    logic [31:0] r;
    md = $urandom_range(0, 4);
    r = $urandom();
    case (md)
      0:       return {1'b1, r[MANT_W:0]};
      1:       return '0;
      2:       return (MANT_W+2)'(r[MANT_W:0] >> $urandom_range(1, MANT_W));
      3:       return {2'b01, r[MANT_W-1:0]};
      default: return r[MANT_W+1:0];
    endcase
  endfunction

  function automatic logic [EXP_W-1:0] rand_exp();
    int md;
    md = $urandom_range(0, 3);
    case (md)
      0:       return EXP_W'($urandom_range(0, 30));
      1:       return EXP_W'($urandom_range(250, 255));
      default: return EXP_W'($urandom());
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MANT_W+1:0] bp_m[4];
    logic [EXP_W-1:0]  bp_e[4];
    int idx;
    int n;
    int sent;
    int cyc;
    bp_m = '{25'h1800000, 25'h0400000, 25'h0000000, 25'h0123456};
    bp_e = '{8'h80, 8'h80, 8'h55, 8'h40};

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", 64'(cur_out()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors
    directed("carry",   1'b1, 8'h80, 25'h1800000, pk(1'b1, 8'h81, 23'h400000, 1'b0, 1'b0, 1'b0));
    directed("lshift1", 1'b0, 8'h80, 25'h0400000, pk(1'b0, 8'h7F, 23'h000000, 1'b0, 1'b0, 1'b0));
    directed("lshift23",1'b0, 8'h20, 25'h0000001, pk(1'b0, 8'h09, 23'h000000, 1'b0, 1'b0, 1'b0));
    directed("zero",    1'b1, 8'h55, 25'h0000000, pk(1'b1, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b0));
    directed("unf",     1'b0, 8'h10, 25'h0000001, pk(1'b0, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b1));
    directed("unf_eq",  1'b0, 8'h01, 25'h0400000, pk(1'b0, 8'h00, 23'h000000, 1'b1, 1'b0, 1'b1));
    directed("min_exp", 1'b0, 8'h02, 25'h0400000, pk(1'b0, 8'h01, 23'h000000, 1'b0, 1'b0, 1'b0));
    directed("ovf",     1'b0, 8'hFE, 25'h1000000, pk(1'b0, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0));
    directed("ovf_ff",  1'b1, 8'hFF, 25'h1FFFFFF, pk(1'b1, 8'hFF, 23'h000000, 1'b0, 1'b1, 1'b0));
    directed("no_ovf",  1'b0, 8'hFD, 25'h1FFFFFF, pk(1'b0, 8'hFE, 23'h7FFFFF, 1'b0, 1'b0, 1'b0));

    // Backpressure: out_ready low for 5 cycles while 4 beats are offered
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(idx < 4, 1'b0, bp_e[idx % 4], bp_m[idx % 4], 1'b0);
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    n = 0;
    while ((idx < 4 || exp_q.size() != 0) && n < 20) begin
      step(idx < 4, 1'b0, bp_e[idx % 4], bp_m[idx % 4], 1'b1);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_sent", 64'(idx), 64'd4);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Random valid/ready traffic
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      step($urandom_range(0, 3) != 0, 1'($urandom()), rand_exp(), rand_mant(),
           $urandom_range(0, 3) != 0);
      if (acc) sent++;
      cyc++;
    end
    chk("rand_sent", 64'(sent), 64'd1000);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with two beats in flight
    step(1'b1, 1'b1, 8'h80, 25'h1800000, 1'b1);
    step(1'b1, 1'b0, 8'h40, 25'h0400000, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outputs", 64'(cur_out()), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    directed("post_rst", 1'b0, 8'h33, 25'h0800001, pk(1'b0, 8'h33, 23'h000001, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("final_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
